// File: rtl/pc_seq_if.sv
// Control/status bundle between the CPU sequencer logic and the program counter.
// master drives control requests and branch data; slave is the program counter.
interface pc_seq_if #(
    parameter int unsigned AW    = 12,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned SPW = $clog2(DEPTH + 1);

    logic          stop;
    logic          resume;
    logic          stall;
    logic          branchRel;
    logic          branchAbs;
    logic          call;
    logic          ret;
    logic [AW-1:0] inData;

    logic [AW-1:0]  insAd;
    logic           halted;
    logic           fault;
    logic [SPW-1:0] sp;
    logic           stackFull;
    logic           stackEmpty;

    modport master (
        output stop, resume, stall, branchRel, branchAbs, call, ret, inData,
        input  insAd, halted, fault, sp, stackFull, stackEmpty
    );

    modport slave (
        input  stop, resume, stall, branchRel, branchAbs, call, ret, inData,
        output insAd, halted, fault, sp, stackFull, stackEmpty
    );
endinterface

// File: rtl/pc_seq.sv
// Program counter with sequential/relative/absolute updates, call/return stack,
// stall and sticky halt; stack faults park the core in S_FAULT until reset.
module pc_seq #(
    parameter int unsigned   AW         = 12,
    parameter int unsigned   DEPTH      = 4,
    parameter logic [AW-1:0] RESET_ADDR = '0
) (
    input  logic     clk,
    input  logic     reset,
    pc_seq_if.slave  bus
);
    localparam int unsigned SPW = $clog2(DEPTH + 1);
    localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // S_HALT and S_FAULT both freeze the PC; only S_HALT responds to resume.
    typedef enum logic [1:0] {
        S_RUN,
        S_HALT,
        S_FAULT
    } state_t;

    state_t         state;
    logic [AW-1:0]  insAd_q;
    logic [SPW-1:0] sp_q;
    logic [AW-1:0]  stack [DEPTH];

    logic           full;
    logic           empty;
    logic [IW-1:0]  push_idx;
    logic [IW-1:0]  pop_idx;
    logic [AW-1:0]  insAd_inc;

    assign full      = (sp_q == SPW'(DEPTH));
    assign empty     = (sp_q == '0);
    assign push_idx  = IW'(sp_q);
    assign pop_idx   = IW'(sp_q - SPW'(1));
    assign insAd_inc = insAd_q + AW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_RUN;
            insAd_q <= RESET_ADDR;
            sp_q    <= '0;
        end else if (bus.stop) begin
            // A stop during a fault must not downgrade it to a resumable halt.
            if (state == S_RUN) begin
                state <= S_HALT;
            end
        end else if (state != S_RUN) begin
            if (state == S_HALT && bus.resume) begin
                state <= S_RUN;
            end
        end else if (bus.stall) begin
            insAd_q <= insAd_q;
        end else if (bus.ret) begin
            if (empty) begin
                state <= S_FAULT;
            end else begin
                insAd_q <= stack[pop_idx];
                sp_q    <= sp_q - SPW'(1);
            end
        end else if (bus.call) begin
            if (full) begin
                state <= S_FAULT;
            end else begin
                stack[push_idx] <= insAd_inc;
                sp_q            <= sp_q + SPW'(1);
                insAd_q         <= bus.inData;
            end
        end else if (bus.branchAbs) begin
            insAd_q <= bus.inData;
        end else if (bus.branchRel) begin
            insAd_q <= insAd_q + bus.inData;
        end else begin
            insAd_q <= insAd_inc;
        end
    end

    assign bus.insAd      = insAd_q;
    assign bus.halted     = (state != S_RUN);
    assign bus.fault      = (state == S_FAULT);
    assign bus.sp         = sp_q;
    assign bus.stackFull  = full;
    assign bus.stackEmpty = empty;
endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program counter for the single-cycle/multi-cycle CPU datapath. Supplies the instruction-memory address each cycle and supports sequential increment, PC-relative branch, absolute jump, subroutine call/return through an internal return-address stack, stall, and sticky halt/resume. All state updates on the rising clock edge only. Faults (stack overflow/underflow) halt the core until reset.

## Interface
Parameters:
- AW, 12, instruction address width in bits
- DEPTH, 4, return-stack entries (≥1)
- RESET_ADDR, 0, insAd value after reset

Ports:
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high
- stop  in  1  request halt
- resume  in  1  leave halt (ignored while fault=1)
- stall  in  1  hold insAd this cycle
- branchRel  in  1  relative branch: insAd + inData
- branchAbs  in  1  absolute jump: inData
- call  in  1  push insAd+1, jump to inData
- ret  in  1  pop return address into insAd
- inData  in  AW  branch offset (two's complement) or target
- insAd  out  AW  current instruction address (register)
- halted  out  1  PC frozen
- fault  out  1  sticky stack overflow/underflow flag
- sp  out  $clog2(DEPTH+1)  occupied stack entries
- stackFull  out  1  sp == DEPTH (combinational)
- stackEmpty  out  1  sp == 0 (combinational)

## Operation
- Reset: insAd=RESET_ADDR, halted=0, fault=0, sp=0; stack contents don't-care. Reset overrides every other input.
- Per-edge priority (first match wins):
  1. reset
  2. stop=1 → halted<=1, insAd holds (stop beats resume)
  3. halted=1 → insAd holds; resume=1 and fault=0 → halted<=0 (insAd advances from next edge)
  4. stall=1 → insAd, sp hold
  5. ret: stackEmpty → fault<=1, halted<=1, insAd holds; else insAd<=stack[sp-1], sp<=sp-1
  6. call: stackFull → fault<=1, halted<=1, insAd holds; else stack[sp]<=insAd+1, sp<=sp+1, insAd<=inData
  7. branchAbs → insAd<=inData
  8. branchRel → insAd<=insAd+inData
  9. otherwise insAd<=insAd+1
- Arithmetic modulo 2^AW; overflow wraps silently (0xFFF+1 → 0x000 at AW=12; insAd=0x010, inData=0xFFE → 0x00E).
- Return address pushed is insAd+1 modulo 2^AW.
- fault cleared only by reset; resume while fault=1 has no effect.
- Lower-priority control inputs active in the same cycle are ignored, not queued.

## Timing
- All control inputs and inData sampled at posedge clk; new insAd visible after that edge (1-cycle latency, no bubble).
- No negedge logic; no combinational path from inputs to insAd.
- halted, fault, sp registered, update on same edge as insAd. stackFull/stackEmpty combinational from sp.
- Back-to-back call/ret on consecutive cycles supported at full rate.
- Halt takes effect on the edge stop is sampled; that edge does not advance insAd.

## Test plan
- Reset then 5 idle cycles → insAd 0,1,2,3,4,5; assert reset at insAd=5 with branchAbs=1 → insAd=0.
- insAd=0x010: branchRel inData=0x005 → 0x015; branchRel inData=0xFFE → 0x013; branchAbs 0xFFF then idle → 0x000 (wrap).
- At insAd=0x020 call 0x100, at 0x100 call 0x200, then ret → 0x101, ret → 0x021; sp 0→1→2→1→0.
- DEPTH=4: five nested calls → fifth sets fault=1, halted=1, insAd unchanged, sp=4; resume ignored; reset clears. Separately ret at sp=0 → fault=1.
- stop at insAd=7 → insAd stays 7 for 3 cycles; stop+resume same cycle → still halted; resume alone → next edge insAd=8.
- stall=1 with call=1 → no push, insAd/sp hold; stall dropped → call executes.
